clk_div_prog: RTL

Programmable integer clock divider producing a 50%-duty `clk_out` for any divisor N ≥ 2, odd or even. It sits upstream of the fixed fractional divider stage and supplies its input clock from the system reference `clk_in`. The divisor can be changed at run time; a change is applied only on an output-period boundary, so `clk_out` never glitches.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_prog_if.sv | 22 ++
 rtl/clk_div_negalign.sv | 20 ++
 rtl/clk_div_prog.sv | 99 +++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, divisor type and helpers for the clock divider
package clk_div_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV_W = 8;

  typedef logic [DEF_DIV_W-1:0] div_t;

  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - divisor load handshake and period status bundle
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
);
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             div_busy;
  logic             div_ack;
  logic             period_start;

  modport master (
    output div_val, div_load,
    input  div_busy, div_ack, period_start
  );

  modport slave (
    input  div_val, div_load,
    output div_busy, div_ack, period_start
  );
endinterface

// File: rtl/clk_div_negalign.sv
// rtl/clk_div_negalign.sv - falling-edge copy of clk_p and the odd/even output combine
module clk_div_negalign (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clk_p_i,
  input  logic clk_e_i,
  input  logic odd_i,
  output logic clk_out_o
);
  logic clk_n_q;

  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) clk_n_q <= 1'b0;
    else        clk_n_q <= clk_p_i;
  end

  // clk_n is low across every period boundary, so odd_i may switch there without
  // a hazard; in even mode only the registered clk_e term moves.
  assign clk_out_o = clk_e_i | (odd_i & clk_p_i & clk_n_q);
endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable 50%-duty integer clock divider with boundary-aligned reload
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int DIV_INIT = 3
) (
  input  logic          clk_in,
  input  logic          rst_n,
  clk_div_prog_if.slave ctrl,
  output logic          clk_out
);
  typedef logic [DIV_W-1:0] cnt_t;

  localparam cnt_t INIT_V = cnt_t'(DIV_INIT);
  localparam cnt_t MIN_V  = cnt_t'(MIN_DIV);
  localparam cnt_t ONE    = cnt_t'(1);

  cnt_t n_act_q,  n_act_d;
  cnt_t n_pend_q, n_pend_d;
  cnt_t cnt_q,    cnt_d;
  logic odd_q,    odd_d;
  logic busy_q,   busy_d;
  logic ack_q,    ack_d;
  logic ps_q,     ps_d;
  logic clk_p_q,  clk_p_d;
  logic clk_e_q,  clk_e_d;
  logic run_q;

  cnt_t load_val;
  cnt_t h_d;
  logic load_acc;
  logic wrap;

  always_comb begin
    load_val = (ctrl.div_val < MIN_V) ? MIN_V : ctrl.div_val;
    load_acc = ctrl.div_load && !busy_q;
    wrap     = run_q && (cnt_q == n_act_q - ONE);

    n_pend_d = load_acc ? load_val : n_pend_q;
    busy_d   = busy_q | load_acc;
    n_act_d  = n_act_q;
    ack_d    = 1'b0;
    cnt_d    = '0;
    if (run_q && !wrap) cnt_d = cnt_q + ONE;

    // A load accepted on the last cycle of a period is applied at that same boundary.
    if (wrap && busy_d) begin
      n_act_d = busy_q ? n_pend_q : load_val;
      busy_d  = 1'b0;
      ack_d   = 1'b1;
    end

    odd_d   = n_act_d[0];
    h_d     = cnt_t'(half_ceil(32'(n_act_d)));
    clk_p_d = (cnt_d < h_d);
    clk_e_d = clk_p_d & ~odd_d;
    ps_d    = (cnt_d == '0);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      n_act_q  <= INIT_V;
      n_pend_q <= INIT_V;
      odd_q    <= INIT_V[0];
      cnt_q    <= '0;
      clk_p_q  <= 1'b0;
      clk_e_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      ps_q     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      n_act_q  <= n_act_d;
      n_pend_q <= n_pend_d;
      odd_q    <= odd_d;
      cnt_q    <= cnt_d;
      clk_p_q  <= clk_p_d;
      clk_e_q  <= clk_e_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      ps_q     <= ps_d;
      run_q    <= 1'b1;
    end
  end

  assign ctrl.div_busy     = busy_q;
  assign ctrl.div_ack      = ack_q;
  assign ctrl.period_start = ps_q;

  clk_div_negalign u_negalign (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clk_p_i   (clk_p_q),
    .clk_e_i   (clk_e_q),
    .odd_i     (odd_q),
    .clk_out_o (clk_out)
  );
endmodule
